shift_left_seq_32bit: RTL

//  Multi-cycle 32-bit logical left shifter, the left-direction counterpart of the ALU's

---
 rtl/shift_left_seq_32bit_pkg.sv | 22 ++
 rtl/shift_left_stage.sv | 32 +++
 rtl/shift_left_seq_32bit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/shift_left_seq_32bit_pkg.sv
// ============================================================================
// shift_left_seq_32bit_pkg : shared ALU widths and shifter state codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package shift_left_seq_32bit_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;
  // Stage counter must also hold the one-past-last value seen in DONE.
  localparam int ALU_STAGE_W = 3;

  typedef enum logic [1:0] {
    SHL_IDLE  = 2'd0,
    SHL_SHIFT = 2'd1,
    SHL_DONE  = 2'd2
  } shl_state_e;

endpackage

`default_nettype wire

// File: rtl/shift_left_stage.sv
// ============================================================================
// shift_left_stage : one log-shifter stage, shifts by 1<<stage_i when enabled
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_left_stage #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  logic [IDX_W-1:0] stage_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] lost_o
);

  logic [6:0]       w_sh;
  logic [WIDTH-1:0] w_ones;
  logic [WIDTH-1:0] w_lost_mask;

  assign w_sh        = 7'd1 << stage_i;
  assign w_ones      = {WIDTH{1'b1}};
  // Top w_sh bits of the operand are the ones pushed off the end.
  assign w_lost_mask = ~(w_ones >> w_sh);

  assign data_o = en_i ? (data_i << w_sh) : data_i;
  assign lost_o = en_i ? (data_i & w_lost_mask) : '0;

endmodule

`default_nettype wire

// File: rtl/shift_left_seq_32bit.sv
// ============================================================================
// shift_left_seq_32bit : multi-cycle zero-fill left shifter, one stage/clock
// Optional lost-bit flag OVF under macro SHL_OVF_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module shift_left_seq_32bit
  import shift_left_seq_32bit_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
`ifdef SHL_OVF_EN
  output logic             OVF,
`endif
  output logic [WIDTH-1:0] Z
);

  shl_state_e               state_q, state_d;
  logic [WIDTH-1:0]         acc_q, acc_d;
  logic [SHAMT_W-1:0]       amt_q, amt_d;
  logic [ALU_STAGE_W-1:0]   stage_q, stage_d;

  logic                     clamp;
  logic                     stage_en;
  logic [WIDTH-1:0]         stage_data;
  logic [WIDTH-1:0]         stage_lost;

  // Negative or >= WIDTH amounts both show up as nonzero upper bits.
  assign clamp    = |Y[WIDTH-1:SHAMT_W];
  assign stage_en = (state_q == SHL_SHIFT) && amt_q[stage_q];

  shift_left_stage #(
    .WIDTH (WIDTH),
    .IDX_W (ALU_STAGE_W)
  ) u_stage (
    .data_i  (acc_q),
    .en_i    (stage_en),
    .stage_i (stage_q),
    .data_o  (stage_data),
    .lost_o  (stage_lost)
  );

`ifdef SHL_OVF_EN
  logic lost_q, lost_d;
`else
  logic unused_lost;
  assign unused_lost = |stage_lost;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHL_IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      stage_q <= '0;
`ifdef SHL_OVF_EN
      lost_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
`ifdef SHL_OVF_EN
      lost_q  <= lost_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    stage_d = stage_q;
`ifdef SHL_OVF_EN
    lost_d  = lost_q;
`endif
    case (state_q)
      SHL_IDLE: begin
        if (IN_VALID) begin
          state_d = SHL_SHIFT;
          acc_d   = clamp ? '0 : X;
          amt_d   = Y[SHAMT_W-1:0];
          stage_d = '0;
`ifdef SHL_OVF_EN
          lost_d  = clamp ? |X : 1'b0;
`endif
        end
      end
      SHL_SHIFT: begin
        acc_d   = stage_data;
        stage_d = stage_q + 1'b1;
`ifdef SHL_OVF_EN
        lost_d  = lost_q | (|stage_lost);
`endif
        if (stage_q == ALU_STAGE_W'(SHAMT_W - 1)) begin
          state_d = SHL_DONE;
        end
      end
      SHL_DONE: begin
        if (OUT_READY) begin
          state_d = SHL_IDLE;
        end
      end
      default: begin
        state_d = SHL_IDLE;
      end
    endcase
  end

  assign IN_READY  = (state_q == SHL_IDLE);
  assign OUT_VALID = (state_q == SHL_DONE);
  assign Z         = OUT_VALID ? acc_q : '0;
`ifdef SHL_OVF_EN
  assign OVF       = OUT_VALID ? lost_q : 1'b0;
`endif

endmodule

`default_nettype wire
